fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined ARM-subset core: owns the program counter, drives the word address of the combinational instruction memory, and registers the returned word with its PC+4 into the IF/ID pipeline register consumed by decode. Handles hazard freeze from decode and branch redirect/flush from execute. Sits between the hazard/branch logic and the instruction memory on one side and the decode stage on the other.

## Interface
- IMEM_WORDS, 1024: instruction memory depth in 32-bit words; sets imem_addr width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- freeze  in  1  hazard stall from decode; hold PC and IF/ID.
- branch_taken  in  1  branch resolved taken in execute; redirect and flush.
- branch_addr  in  32  byte target address; bits [1:0] ignored (forced 0).
- imem_addr  out  $clog2(IMEM_WORDS)  word index to instruction memory, = pc[..:2].
- imem_data  in  32  instruction word, combinational from imem_addr same cycle.
- pc  out  32  current fetch byte address.
- if_id_pc4  out  32  registered PC+4 of the held instruction.
- if_id_instr  out  32  registered instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.

## Operation
- FSM states: BOOT, RUN, FROZEN.
- rst=1: state to BOOT, pc=0, if_id_instr=32'hE000_0000 (NOP), if_id_pc4=0, if_id_valid=0. Reset mid-operation discards everything in the same way.
- BOOT (exactly one cycle after rst falls; imem contents settling): pc held at 0, IF/ID loads NOP/valid=0, go to RUN. branch_taken/freeze ignored in BOOT.
- RUN, no events: pc <= pc+4; IF/ID <= {pc+4, imem_data, valid=1}.
- freeze=1 (and branch_taken=0): pc and all IF/ID fields hold; state FROZEN. FROZEN returns to RUN on the first cycle freeze=0, with the same action as RUN in that cycle.
- branch_taken=1 (RUN or FROZEN): pc <= {branch_addr[31:2],2'b00}; IF/ID <= NOP, pc4=0, valid=0; state RUN. Branch has priority over freeze in the same cycle.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0. imem_addr takes the low bits of pc[31:2] (wraps modulo IMEM_WORDS).
- imem_data is never used as a bubble marker; bubbles are signalled only by if_id_valid=0.

## Timing
- Fetch latency: instruction at pc visible on if_id_instr one edge after pc is presented.
- Redirect: target fetched the cycle after branch_taken; exactly one bubble is inserted (the wrong-path word in IF/ID); decode/execute flush beyond IF/ID is not this block's job.
- Freeze acts on the same edge it is sampled; no skid.
- All outputs change only on rising clk; pc and imem_addr are registered-derived, with no combinational path from inputs.

## Configuration
- FETCH_PERF_EN defined: adds outputs fetch_count (32) and stall_count (32), reset to 0 by rst. fetch_count increments on every edge where IF/ID loads valid=1; stall_count on every edge in which freeze=1 and branch_taken=0 outside BOOT. Both saturate at 32'hFFFF_FFFF.
- Not defined: ports and counters absent; all other behaviour identical.

## Structure
- Shared cpu_pkg: NOP_INSTR = 32'hE000_0000, XLEN = 32, fetch FSM state enum.
- Sub-module if_id_reg: pc4/instr/valid register with load, hold (freeze) and flush (branch/boot/reset) controls; fetch_stage holds the PC, FSM and optional counters.

## Test plan
- Reset 2 cycles then release -> pc=0, IF/ID NOP/valid=0 through the BOOT cycle; next edge if_id_pc4=4, if_id_instr=ROM[0], valid=1.
- ROM[0..3]=A,B,C,D, no events -> if_id_instr A,B,C,D on successive edges, if_id_pc4 4,8,12,16, imem_addr 0,1,2,3.
- freeze high 3 cycles while pc=8 -> pc=8, imem_addr=2, IF/ID stays {8,B,1}; first edge after release loads {12,C,1}.
- branch_taken with branch_addr=32'h43 at pc=12 -> next edge pc=32'h40, IF/ID NOP/valid=0; following edge {32'h44, ROM[16], 1}.
- branch_taken and freeze both high -> branch taken, IF/ID flushed, state RUN; also pc preloaded to 32'hFFFF_FFFC via branch -> after one RUN edge pc=0.
- With FETCH_PERF_EN: 5 valid fetches, 2 freeze cycles, then rst -> counts 5/2, then 0/0 after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM-subset pipeline: word size, the canonical NOP,
// fetch FSM states and the IF/ID register payload.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'hE000_0000;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_FROZEN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};

  // Saturating increment for the optional performance counters.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush (reset/boot/branch) beats load, and neither
// asserted holds the current contents (freeze).
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc4_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] instr,
  output logic            valid
);

  if_id_t q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= IF_ID_BUBBLE;
    end else if (load) begin
      q <= '{pc4: pc4_in, instr: instr_in, valid: 1'b1};
    end
  end

  assign pc4   = q.pc4;
  assign instr = q.instr;
  assign valid = q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, BOOT/RUN/FROZEN FSM and IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch_count / stall_count outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          freeze,
  input  logic                          branch_taken,
  input  logic [XLEN-1:0]               branch_addr,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  input  logic [XLEN-1:0]               imem_data,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               if_id_pc4,
  output logic [XLEN-1:0]               if_id_instr,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0]               fetch_count,
  output logic [XLEN-1:0]               stall_count,
`endif
  output logic                          if_id_valid
);

  localparam int AW = $clog2(IMEM_WORDS);

  fetch_state_e state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] pc_plus4;
  logic            ifid_load;
  logic            ifid_flush;

  // Low two bits of the branch target are architecturally ignored.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_addr[1:0];

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_BOOT:           state_nxt = FS_RUN;
      FS_RUN, FS_FROZEN: begin
        if (branch_taken)  state_nxt = FS_RUN;
        else if (freeze)   state_nxt = FS_FROZEN;
        else               state_nxt = FS_RUN;
      end
      default:           state_nxt = FS_BOOT;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    pc_nxt     = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state)
      FS_BOOT: ifid_flush = 1'b1;
      FS_RUN, FS_FROZEN: begin
        if (branch_taken) begin
          pc_nxt     = {branch_addr[XLEN-1:2], 2'b00};
          ifid_flush = 1'b1;
        end else if (!freeze) begin
          pc_nxt    = pc_plus4;
          ifid_load = 1'b1;
        end
      end
      default: ifid_flush = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else begin
      pc <= pc_nxt;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .pc4_in   (pc_plus4),
    .instr_in (imem_data),
    .pc4      (if_id_pc4),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

`ifdef FETCH_PERF_EN
  logic stall_event;
  assign stall_event = (state != FS_BOOT) && freeze && !branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ifid_load)   fetch_count <= sat_inc(fetch_count);
      if (stall_event) stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule
